// File: rtl/i2c_tx_srg_pkg.sv
// Shared types and sizing constants for the I2C slave transmit path.
package i2c_tx_srg_pkg;

   // Number of filter taps held in the coefficient bank.
   localparam int NTAPS = 4;

   // Bytes read out per transfer: one 16-bit coefficient per tap.
   localparam int TX_BYTES = NTAPS * 2;

   // Transmit shift register states.
   typedef enum logic [1:0] {
      TX_IDLE     = 2'd0,
      TX_SHIFT    = 2'd1,
      TX_WAIT_ACK = 2'd2
   } i2c_tx_state_t;

endpackage : i2c_tx_srg_pkg

// File: rtl/i2c_tx_srg.sv
// Parallel-in/serial-out transmit shift register for the I2C slave read path.
// A loaded word is sent MSB first, one bit per shift strobe, byte by byte,
// with the bus released while the master ACKs or NACKs each byte.
module i2c_tx_srg
   import i2c_tx_srg_pkg::*;
#(
   parameter int DATA_BYTES = TX_BYTES
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load_in,
   input  logic [DATA_BYTES*8-1:0] data_in,
   input  logic                    shift_in,
   input  logic                    ack_valid_in,
   input  logic                    ack_in,
   output logic                    bit_out,
   output logic                    byte_done_out,
   output logic                    last_byte_out,
   output logic                    busy_out,
   output logic                    underrun_out
);

   localparam int W   = DATA_BYTES * 8;
   localparam int BCW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
   localparam logic [BCW-1:0] LAST_IDX = BCW'(DATA_BYTES - 1);

   i2c_tx_state_t  state_reg;
   i2c_tx_state_t  state_next;
   logic [W-1:0]   srg_reg;
   logic [2:0]     bit_cnt_reg;
   logic [BCW-1:0] byte_cnt_reg;
   logic           byte_done_reg;
   logic           underrun_reg;

   logic           last_byte;
   logic           last_bit;

   assign last_byte = (byte_cnt_reg == LAST_IDX);
   assign last_bit  = (bit_cnt_reg == 3'd7);

   // Next-state decode: a load always (re)starts a transfer, even mid-byte.
   always_comb begin
      state_next = state_reg;
      if (load_in) begin
         state_next = TX_SHIFT;
      end else begin
         case (state_reg)
            TX_IDLE: begin
               state_next = TX_IDLE;
            end
            TX_SHIFT: begin
               if (shift_in && last_bit) begin
                  state_next = TX_WAIT_ACK;
               end
            end
            TX_WAIT_ACK: begin
               if (ack_valid_in) begin
                  if (ack_in || last_byte) begin
                     state_next = TX_IDLE;
                  end else begin
                     state_next = TX_SHIFT;
                  end
               end
            end
            default: begin
               state_next = TX_IDLE;
            end
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= TX_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Shift register, bit/byte counters, byte-done pulse and sticky underrun flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         srg_reg       <= '0;
         bit_cnt_reg   <= '0;
         byte_cnt_reg  <= '0;
         byte_done_reg <= 1'b0;
         underrun_reg  <= 1'b0;
      end else begin
         byte_done_reg <= 1'b0;
         if (load_in) begin
            srg_reg      <= data_in;
            bit_cnt_reg  <= '0;
            byte_cnt_reg <= '0;
            underrun_reg <= 1'b0;
         end else begin
            case (state_reg)
               TX_SHIFT: begin
                  if (shift_in) begin
                     srg_reg <= {srg_reg[W-2:0], 1'b0};
                     if (last_bit) begin
                        bit_cnt_reg   <= '0;
                        byte_done_reg <= 1'b1;
                     end else begin
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                     end
                  end
               end
               TX_WAIT_ACK: begin
                  // An ACK on the final byte means the master wants more than
                  // we have; the bus stays released so it reads 0xFF.
                  if (ack_valid_in && !ack_in) begin
                     if (last_byte) begin
                        underrun_reg <= 1'b1;
                     end else begin
                        byte_cnt_reg <= byte_cnt_reg + 1'b1;
                     end
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign busy_out      = (state_reg != TX_IDLE);
   assign bit_out       = (state_reg == TX_SHIFT) ? srg_reg[W-1] : 1'b1;
   assign byte_done_out = byte_done_reg;
   assign last_byte_out = busy_out & last_byte;
   assign underrun_out  = underrun_reg;

endmodule : i2c_tx_srg
